nand_op_sequencer: RTL and testbench

Operation-level sequencer that sits between the host/APB register file and the NAND bus-cycle engine. It accepts one whole flash operation at a time (reset, page read, page program, block erase) and breaks it into the ordered command, address and data bus cycles. It moves data between the Tx/Rx FIFOs and the cycle engine, waits on the device ready/busy line, and reports completion or timeout to the host.

---
 rtl/nand_op_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_nand_op_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_op_sequencer.sv
// NAND operation sequencer: splits one host flash operation into ordered command,
// address and data bus cycles, waits on ready/busy and reports done or timeout.
//
// state       | meaning
// IDLE        | waiting for a host request
// CMD1        | first command cycle
// ADDR        | address cycles (5 bytes, or 3 row bytes for erase)
// ADL_WAIT    | address-to-data gap before program data
// WDATA       | write data taken from the Tx FIFO
// CMD2        | confirm command
// BUSY_WAIT   | ready/busy wait with tWB blanking and timeout
// RDATA       | read data pushed into the Rx FIFO
// DONE        | one-cycle completion pulse
module nand_op_sequencer #(
   parameter int ADL_CYC = 7,
   parameter int WB_CYC  = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic        P_clk,
   input  logic        P_nrst,
   input  logic        H_Valid,
   output logic        H_Ready,
   input  logic [1:0]  H_Op,
   input  logic [39:0] H_Addr,
   input  logic [7:0]  H_Length,
   output logic        H_Done,
   output logic        H_Err,
   output logic        B_Req,
   output logic [1:0]  B_Type,
   output logic [7:0]  B_Data,
   input  logic        B_Ack,
   input  logic [7:0]  B_RdData,
   input  logic [7:0]  Tx_Data,
   input  logic        Tx_Empty,
   output logic        Tx_Pop,
   output logic [7:0]  Rx_Data,
   input  logic        Rx_Full,
   output logic        Rx_Push,
   input  logic        F_nRB,
   output logic        F_nWP
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD1, S_ADDR, S_ADL_WAIT, S_WDATA, S_CMD2, S_BUSY_WAIT, S_RDATA, S_DONE
   } state_t;

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_PROG  = 2'b10;
   localparam logic [1:0] OP_ERASE = 2'b11;

   localparam logic [1:0] BT_CMD  = 2'b00;
   localparam logic [1:0] BT_ADDR = 2'b01;
   localparam logic [1:0] BT_WR   = 2'b10;
   localparam logic [1:0] BT_RD   = 2'b11;

   localparam logic [15:0] ADL_TC = 16'(ADL_CYC - 1);
   localparam logic [15:0] WB_TC  = 16'(WB_CYC);
   localparam logic [15:0] TO_TC  = 16'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [1:0]    op_q;
   logic [39:0]   addr_q;
   logic [7:0]    len_q;
   logic [7:0]    byte_q, byte_d;
   logic [2:0]    idx_q, idx_d;
   logic [15:0]   tmr_q, tmr_d;
   logic          err_q, err_d;
   logic          nwp_q, nwp_d;
   logic          rb_meta_q, rb_s_q;

   logic          accept;
   logic [7:0]    cmd1, cmd2;
   logic [2:0]    addr_sel;
   logic          addr_last;
   logic [7:0]    addr_byte;
   logic [7:0]    byte_inc;

   assign accept    = (state_q == S_IDLE) && H_Valid;
   assign H_Ready   = (state_q == S_IDLE);
   assign H_Err     = err_q;
   assign F_nWP     = nwp_q;
   assign Rx_Data   = B_RdData;
   assign byte_inc  = byte_q + 8'd1;
   assign addr_byte = addr_q[{addr_sel, 3'b000} +: 8];

   // Erase only sends the three row bytes, so its address index is offset by two.
   always_comb begin
      cmd1      = 8'hFF;
      cmd2      = 8'h30;
      addr_sel  = idx_q;
      addr_last = (idx_q == 3'd4);
      case (op_q)
         OP_READ:  cmd1 = 8'h00;
         OP_PROG:  begin
            cmd1 = 8'h80;
            cmd2 = 8'h10;
         end
         OP_ERASE: begin
            cmd1      = 8'h60;
            cmd2      = 8'hD0;
            addr_sel  = idx_q + 3'd2;
            addr_last = (idx_q == 3'd2);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      nwp_d   = nwp_q;
      B_Req   = 1'b0;
      B_Type  = BT_CMD;
      B_Data  = 8'h00;
      Tx_Pop  = 1'b0;
      Rx_Push = 1'b0;
      H_Done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (H_Valid) begin
               state_d = S_CMD1;
               err_d   = 1'b0;
               nwp_d   = H_Op[1];
            end
         end
         S_CMD1: begin
            B_Req  = 1'b1;
            B_Data = cmd1;
            if (B_Ack) begin
               idx_d   = 3'd0;
               tmr_d   = 16'd0;
               state_d = (op_q == OP_RESET) ? S_BUSY_WAIT : S_ADDR;
            end
         end
         S_ADDR: begin
            B_Req  = 1'b1;
            B_Type = BT_ADDR;
            B_Data = addr_byte;
            if (B_Ack) begin
               idx_d = idx_q + 3'd1;
               if (addr_last) begin
                  if (op_q == OP_PROG) begin
                     tmr_d   = ADL_TC;
                     state_d = S_ADL_WAIT;
                  end else begin
                     state_d = S_CMD2;
                  end
               end
            end
         end
         S_ADL_WAIT: begin
            if (tmr_q == 16'd0) begin
               byte_d  = 8'd0;
               state_d = (len_q == 8'd0) ? S_CMD2 : S_WDATA;
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
         S_WDATA: begin
            B_Req  = !Tx_Empty;
            B_Type = BT_WR;
            B_Data = Tx_Data;
            if (B_Req && B_Ack) begin
               Tx_Pop = 1'b1;
               byte_d = byte_inc;
               if (byte_inc == len_q) state_d = S_CMD2;
            end
         end
         S_CMD2: begin
            B_Req  = 1'b1;
            B_Data = cmd2;
            if (B_Ack) begin
               tmr_d   = 16'd0;
               state_d = S_BUSY_WAIT;
            end
         end
         // rb_s is blanked for the first WB_CYC cycles; ready wins over a same-cycle timeout.
         S_BUSY_WAIT: begin
            if ((tmr_q >= WB_TC) && rb_s_q) begin
               byte_d  = 8'd0;
               state_d = ((op_q == OP_READ) && (len_q != 8'd0)) ? S_RDATA : S_DONE;
            end else if (tmr_q == TO_TC) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_RDATA: begin
            B_Req  = !Rx_Full;
            B_Type = BT_RD;
            if (B_Req && B_Ack) begin
               Rx_Push = 1'b1;
               byte_d  = byte_inc;
               if (byte_inc == len_q) state_d = S_DONE;
            end
         end
         S_DONE: begin
            H_Done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_DONE) nwp_d = 1'b0;
   end

   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         state_q <= S_IDLE;
         byte_q  <= 8'd0;
         idx_q   <= 3'd0;
         tmr_q   <= 16'd0;
         err_q   <= 1'b0;
         nwp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         err_q   <= err_d;
         nwp_q   <= nwp_d;
      end
   end

   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         op_q   <= OP_RESET;
         addr_q <= 40'd0;
         len_q  <= 8'd0;
      end else if (accept) begin
         op_q   <= H_Op;
         addr_q <= H_Addr;
         len_q  <= H_Length;
      end
   end

   always_ff @(posedge P_clk or negedge P_nrst) begin
      if (!P_nrst) begin
         rb_meta_q <= 1'b1;
         rb_s_q    <= 1'b1;
      end else begin
         rb_meta_q <= F_nRB;
         rb_s_q    <= rb_meta_q;
      end
   end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Randomized bench for nand_op_sequencer: plays cycle engine, FIFOs and flash device
// against a list of expected bus cycles built from the operation rules.
module tb_nand_op_sequencer;

   localparam int ADL = 7;
   localparam int WB  = 4;
   localparam int TO  = 200;

   localparam logic [1:0] T_CMD  = 2'b00;
   localparam logic [1:0] T_ADDR = 2'b01;
   localparam logic [1:0] T_WR   = 2'b10;
   localparam logic [1:0] T_RD   = 2'b11;

   logic        P_clk = 1'b0;
   logic        P_nrst;
   logic        H_Valid;
   logic        H_Ready;
   logic [1:0]  H_Op;
   logic [39:0] H_Addr;
   logic [7:0]  H_Length;
   logic        H_Done;
   logic        H_Err;
   logic        B_Req;
   logic [1:0]  B_Type;
   logic [7:0]  B_Data;
   logic        B_Ack;
   logic [7:0]  B_RdData;
   logic [7:0]  Tx_Data;
   logic        Tx_Empty;
   logic        Tx_Pop;
   logic [7:0]  Rx_Data;
   logic        Rx_Full;
   logic        Rx_Push;
   logic        F_nRB;
   logic        F_nWP;

   always #5 P_clk = ~P_clk;

   nand_op_sequencer #(.ADL_CYC(ADL), .WB_CYC(WB), .TIMEOUT(TO)) dut (
      .P_clk(P_clk), .P_nrst(P_nrst),
      .H_Valid(H_Valid), .H_Ready(H_Ready), .H_Op(H_Op), .H_Addr(H_Addr),
      .H_Length(H_Length), .H_Done(H_Done), .H_Err(H_Err),
      .B_Req(B_Req), .B_Type(B_Type), .B_Data(B_Data), .B_Ack(B_Ack),
      .B_RdData(B_RdData), .Tx_Data(Tx_Data), .Tx_Empty(Tx_Empty), .Tx_Pop(Tx_Pop),
      .Rx_Data(Rx_Data), .Rx_Full(Rx_Full), .Rx_Push(Rx_Push),
      .F_nRB(F_nRB), .F_nWP(F_nWP)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [9:0] exp_q[$];
   logic [7:0] tx_q[$];
   logic [7:0] tx_seed[$];
   logic [7:0] rd_src[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_reset();
      P_nrst   = 1'b0;
      H_Valid  = 1'b0;
      H_Op     = 2'b00;
      H_Addr   = 40'd0;
      H_Length = 8'd0;
      B_Ack    = 1'b0;
      B_RdData = 8'd0;
      Tx_Data  = 8'd0;
      Tx_Empty = 1'b1;
      Rx_Full  = 1'b0;
      F_nRB    = 1'b1;
      repeat (3) @(negedge P_clk);
      check("rst_ready",  32'(H_Ready), 1);
      check("rst_breq",   32'(B_Req),   0);
      check("rst_btype",  32'(B_Type),  0);
      check("rst_bdata",  32'(B_Data),  0);
      check("rst_done",   32'(H_Done),  0);
      check("rst_err",    32'(H_Err),   0);
      check("rst_txpop",  32'(Tx_Pop),  0);
      check("rst_rxpush", 32'(Rx_Push), 0);
      check("rst_nwp",    32'(F_nWP),   0);
      P_nrst = 1'b1;
   endtask

   // Expected bus cycles for one operation; returns the index of the cycle that starts the busy wait.
   task automatic build(input logic [1:0] op, input logic [39:0] addr, input int len,
                        input bit to, output int busy_idx);
      logic [7:0] b;
      exp_q.delete();
      tx_q.delete();
      busy_idx = 0;
      case (op)
         2'b00: exp_q.push_back({T_CMD, 8'hFF});
         2'b01: begin
            exp_q.push_back({T_CMD, 8'h00});
            for (int i = 0; i < 5; i++) exp_q.push_back({T_ADDR, addr[8*i +: 8]});
            exp_q.push_back({T_CMD, 8'h30});
            busy_idx = 6;
            if (!to) for (int i = 0; i < len; i++) exp_q.push_back({T_RD, 8'h00});
         end
         2'b10: begin
            exp_q.push_back({T_CMD, 8'h80});
            for (int i = 0; i < 5; i++) exp_q.push_back({T_ADDR, addr[8*i +: 8]});
            for (int i = 0; i < len; i++) begin
               b = (tx_seed.size() > 0) ? tx_seed.pop_front() : 8'($urandom);
               tx_q.push_back(b);
               exp_q.push_back({T_WR, b});
            end
            exp_q.push_back({T_CMD, 8'h10});
            busy_idx = 6 + len;
         end
         default: begin
            exp_q.push_back({T_CMD, 8'h60});
            for (int i = 2; i < 5; i++) exp_q.push_back({T_ADDR, addr[8*i +: 8]});
            exp_q.push_back({T_CMD, 8'hD0});
            busy_idx = 4;
         end
      endcase
   endtask

   task automatic run_op(input logic [1:0] op, input logic [39:0] addr, input int len,
                         input bit to, input int busy_len, input int gap, input int abort_at);
      int  busy_idx, acc_n, busy_k, since_acc, since_addr, tx_gap, rx_full_cnt;
      bit  in_busy, first_wr, done, aborted, ack, acc;
      logic [1:0] t;
      build(op, addr, len, to, busy_idx);
      acc_n = 0; busy_k = -1000; since_addr = 0; tx_gap = 0; rx_full_cnt = 0;
      in_busy = 0; first_wr = 1; done = 0; aborted = 0;

      @(negedge P_clk);
      check("ready_idle", 32'(H_Ready), 1);
      H_Valid = 1'b1; H_Op = op; H_Addr = addr; H_Length = 8'(len); B_Ack = 1'b0;
      since_acc = 0;

      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(negedge P_clk);
         since_acc++;
         since_addr++;
         if (in_busy) busy_k++;
         if (H_Done) begin
            done = 1;
            check("done_items", 32'(exp_q.size()), 0);
            check("done_err", 32'(H_Err), 32'(to));
            if (to) check("timeout_lat", busy_k, TO);
            else if (op != 2'b01 || len == 0) check("ready_lat", busy_k, busy_len + 3);
            H_Valid = 1'b0; B_Ack = 1'b0; in_busy = 0; F_nRB = 1'b1;
         end else begin
            check("ready_low", 32'(H_Ready), 0);
            check("nwp_op", 32'(F_nWP), 32'(op[1]));
            H_Valid  = ($urandom_range(0, 3) == 0);
            H_Op     = 2'($urandom);
            H_Addr   = {8'($urandom), $urandom};
            H_Length = 8'($urandom);
            F_nRB    = !(in_busy && (to || busy_k < busy_len));
            if (tx_gap > 0) begin
               Tx_Empty = 1'b1;
               tx_gap--;
            end else begin
               Tx_Empty = (tx_q.size() == 0) || ($urandom_range(0, 7) == 0);
            end
            Tx_Data = Tx_Empty ? 8'($urandom) : tx_q[0];
            if (rx_full_cnt > 0) begin
               Rx_Full = 1'b1;
               rx_full_cnt--;
            end else if ($urandom_range(0, 19) == 0) begin
               Rx_Full = 1'b1;
               rx_full_cnt = 9;
            end else begin
               Rx_Full = 1'b0;
            end
            B_RdData = (rd_src.size() > 0) ? rd_src[0] : 8'($urandom);
            #1;
            if (since_acc == 1) check("req_latency", 32'(B_Req), 1);
            if (B_Req) begin
               if (exp_q.size() == 0) check("extra_req", 32'(B_Req), 0);
               else begin
                  t = exp_q[0][9:8];
                  check("b_type", 32'(B_Type), 32'(t));
                  if (t != T_RD) check("b_data", 32'(B_Data), 32'(exp_q[0][7:0]));
                  if (B_Type == T_WR) check("wr_tx_empty", 32'(Tx_Empty), 0);
                  if (B_Type == T_RD) check("rd_rx_full", 32'(Rx_Full), 0);
                  if (B_Type == T_WR && first_wr) begin
                     check("adl_gap", 32'(since_addr >= ADL + 1), 1);
                     first_wr = 0;
                  end
               end
            end
            ack   = B_Req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
            B_Ack = ack;
            #1;
            acc = B_Req && B_Ack && (exp_q.size() > 0);
            check("tx_pop", 32'(Tx_Pop), 32'(acc && B_Type == T_WR));
            check("rx_push", 32'(Rx_Push), 32'(acc && B_Type == T_RD));
            if (Rx_Push) check("rx_data", 32'(Rx_Data), 32'(B_RdData));
            if (acc) begin
               t = exp_q[0][9:8];
               if (t == T_WR && tx_q.size() > 0) begin
                  void'(tx_q.pop_front());
                  tx_gap = (gap >= 0) ? gap : $urandom_range(0, 5);
               end
               if (t == T_RD && rd_src.size() > 0) void'(rd_src.pop_front());
               if (t == T_ADDR) since_addr = 0;
               if (acc_n == busy_idx) begin
                  in_busy = 1;
                  busy_k  = -1;
               end
               void'(exp_q.pop_front());
               acc_n++;
            end
            if (abort_at >= 0 && acc_n == abort_at) begin
               #1;
               P_nrst = 1'b0;
               B_Ack  = 1'b1;
               #1;
               check("arst_breq",  32'(B_Req),   0);
               check("arst_ready", 32'(H_Ready), 1);
               check("arst_nwp",   32'(F_nWP),   0);
               check("arst_txpop", 32'(Tx_Pop),  0);
               check("arst_btype", 32'(B_Type),  0);
               check("arst_bdata", 32'(B_Data),  0);
               check("arst_done",  32'(H_Done),  0);
               exp_q.delete();
               tx_q.delete();
               in_busy = 0;
               aborted = 1;
               done    = 1;
               repeat (2) @(negedge P_clk);
               H_Valid = 1'b0; B_Ack = 1'b0; F_nRB = 1'b1; Tx_Empty = 1'b1; Rx_Full = 1'b0;
               P_nrst = 1'b1;
            end
         end
      end
      check("op_budget", 32'(done), 1);
      if (!done) do_reset();
      else if (!aborted) begin
         @(negedge P_clk);
         check("done_pulse", 32'(H_Done), 0);
         check("ready_next", 32'(H_Ready), 1);
         check("nwp_idle", 32'(F_nWP), 0);
      end
      rd_src.delete();
      tx_seed.delete();
   endtask

   initial begin : main
      logic [1:0] r_op;
      int         r_len;
      bit         r_to;
      do_reset();

      run_op(2'b11, 40'h0504030201, 0, 1'b0, 20, -1, -1);
      rd_src = '{8'hAA, 8'hBB, 8'hCC};
      run_op(2'b01, 40'h1122334455, 3, 1'b0, 12, -1, -1);
      tx_seed = '{8'h11, 8'h22};
      run_op(2'b10, 40'h00A0B0C0D0, 2, 1'b0, 15, 5, -1);
      run_op(2'b00, 40'h0, 0, 1'b1, 0, -1, -1);
      run_op(2'b01, 40'h0102030405, 30, 1'b0, 8, -1, -1);
      run_op(2'b10, 40'hFEDCBA9876, 6, 1'b0, 10, -1, 8);
      run_op(2'b00, 40'h0, 0, 1'b0, 9, -1, -1);

      for (int n = 0; n < 40; n++) begin
         r_op  = 2'($urandom);
         r_len = $urandom_range(0, 20);
         r_to  = ($urandom_range(0, 7) == 0);
         run_op(r_op, {8'($urandom), $urandom}, r_len, r_to, $urandom_range(5, 40), -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
